// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch sequencer.
//   fetch_state_t : IDLE / RUN / FAULT encoding of the fetch FSM
//   INST_NOP      : canonical RISC-V nop (addi x0, x0, 0)
//   PC_STEP       : byte increment between sequential instruction words
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h00000013;
  localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer. Owns the PC, presents it to a
// combinational word-addressed ROM and registers the returned word together
// with its PC in a one-entry output buffer handed to decode by valid/ready.
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   fetch_en          : permits new fetches (0 = stall)
//   redirect_valid/pc : taken branch/jump from execute; target is word-aligned here
//   imem_addr         : byte address to the ROM (always equals pc)
//   imem_data         : ROM read data for imem_addr, same cycle
//   inst_valid/ready  : output register handshake with decode
//   inst_out, inst_pc : fetched instruction and its PC
//   fetch_fault       : high while the FSM sits in FAULT
//
// Build option FETCH_BOUNDS_CHECK_EN: when defined, a fetch from a PC at or
// beyond the end of the ROM (4*MEM_DEPTH bytes) parks the FSM in FAULT until a
// redirect. When undefined, no check is made, FAULT is unreachable and
// fetch_fault is tied low.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      MEM_DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] inst_pc,
  output logic             fetch_fault
);

  fetch_state_t     state;
  fetch_state_t     next_state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] redirect_target;
  logic             can_fetch;
  logic             capture;
  logic             bounds_trap;
  logic             drain;

`ifdef FETCH_BOUNDS_CHECK_EN
  // One extra bit so a ROM that fills the whole address space still compares correctly.
  localparam logic [WIDTH:0] PC_LIMIT = (WIDTH+1)'(64'(MEM_DEPTH) * 64'd4);
`endif

  assign redirect_target = {redirect_pc[WIDTH-1:2], 2'b00};
  assign imem_addr       = pc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. IDLE only lasts one cycle after reset; FAULT is left
  // only by a redirect, which always returns the sequencer to RUN.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = RUN;
      RUN:     next_state = bounds_trap ? FAULT : RUN;
      FAULT:   next_state = redirect_valid ? RUN : FAULT;
      default: next_state = IDLE;
    endcase
  end

  // Control decode. A redirect pre-empts everything in the cycle it arrives,
  // so a fetch is only considered in RUN without a redirect, and only when the
  // output register is empty or being emptied by decode this very edge.
  always_comb begin
    can_fetch = (state == RUN) && !redirect_valid && fetch_en &&
                (!inst_valid || inst_ready);
`ifdef FETCH_BOUNDS_CHECK_EN
    bounds_trap = can_fetch && ({1'b0, pc} >= PC_LIMIT);
    fetch_fault = (state == FAULT);
`else
    bounds_trap = 1'b0;
    fetch_fault = 1'b0;
`endif
    capture = can_fetch && !bounds_trap;
    drain   = (state == RUN) && !redirect_valid && !can_fetch &&
              inst_valid && inst_ready;
  end

  // PC and output register. A redirect flushes the held entry but leaves the
  // stale data in place; only inst_valid says whether it means anything.
  // A bounds trap keeps the offending pc so software can see where it failed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
    end else if (redirect_valid) begin
      pc         <= redirect_target;
      inst_valid <= 1'b0;
    end else if (capture) begin
      inst_out   <= imem_data;
      inst_pc    <= pc;
      inst_valid <= 1'b1;
      pc         <= pc + WIDTH'(PC_STEP);
    end else if (drain || bounds_trap || (state == FAULT)) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch sequencer for the RISC-V core. It owns the program counter and drives the word-addressed instruction ROM, whose read is combinational. Each fetched word and its PC go into a one-entry output register with a valid/ready handshake to decode. It also accepts redirects from the execute stage and, when configured, traps fetches outside the ROM.

## Interface
Parameters:
- WIDTH, 32: address/instruction width.
- RESET_PC, 0: PC loaded at reset; must be 4-byte aligned.
- MEM_DEPTH, 32: number of ROM words; legal byte addresses are 0 .. 4*MEM_DEPTH-1.

Ports (one clock; reset is asynchronous and active-high):
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- fetch_en, input, 1: permits new fetches; 0 = core stall.
- redirect_valid, input, 1: branch/jump taken this cycle.
- redirect_pc, input, WIDTH: redirect target; bits [1:0] are ignored (forced to 0).
- imem_addr, output, WIDTH: byte address to the ROM; equals pc.
- imem_data, input, WIDTH: ROM read data for imem_addr, same cycle.
- inst_valid, output, 1: output register holds an instruction.
- inst_ready, input, 1: decode accepts inst_out this cycle.
- inst_out, output, WIDTH: fetched instruction.
- inst_pc, output, WIDTH: PC of inst_out.
- fetch_fault, output, 1: high while in FAULT (see Configuration).

## Operation
- State machine has three states: IDLE, RUN, FAULT.
- Reset values:
  - state = IDLE, pc = RESET_PC.
  - inst_valid = 0, inst_out = 0, inst_pc = 0, fetch_fault = 0.
- IDLE: moves to RUN on the next clk unconditionally. No fetch occurs in IDLE. A redirect in IDLE loads pc.
- RUN, with events in priority order:
  1. Redirect: pc <= {redirect_pc[WIDTH-1:2],2'b00}; inst_valid <= 0 (flush, even if inst_ready is also high); no fetch this cycle.
  2. Fetch fires when fetch_en && (!inst_valid || inst_ready):
     - inst_out <= imem_data, inst_pc <= pc, inst_valid <= 1.
     - pc <= pc + 4, modulo 2^WIDTH.
  3. Otherwise, if inst_ready && inst_valid: inst_valid <= 0.
  4. Otherwise the output register and pc hold.
- Output handshake:
  - inst_out and inst_pc stay stable while inst_valid && !inst_ready.
  - A transfer occurs on a clk edge where inst_valid && inst_ready.
- FAULT:
  - No fetches; inst_valid <= 0; fetch_fault = 1.
  - Exits only via redirect, which loads pc and returns to RUN, or via rst.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight instruction is discarded.

## Timing
- Throughput is one instruction per cycle while fetch_en=1 and decode keeps inst_ready=1.
- Reset release: first clk edge goes to RUN; the second edge captures the instruction at RESET_PC. inst_valid is high 2 cycles after reset release.
- Redirect-to-valid latency is 2 cycles: the redirect edge loads pc, and the next edge captures the target.
- Redirect and a fetch-enabling condition in the same cycle: the redirect wins and nothing is captured.
- fetch_en=0 with inst_valid && inst_ready: the entry drains; pc holds.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined:
  - In RUN, if a fetch would fire with pc >= 4*MEM_DEPTH, no capture occurs.
  - The FSM enters FAULT, fetch_fault rises on that edge, and pc holds the offending address.
  - A redirect in the same cycle takes priority; no fault is raised.
- FETCH_BOUNDS_CHECK_EN undefined:
  - No check is made. The ROM index wraps by address truncation and FAULT is unreachable.
  - fetch_fault is tied to 0.

## Structure
- Shared package fetch_pkg holds:
  - the state enumeration (IDLE=2'd0, RUN=2'd1, FAULT=2'd2);
  - INST_NOP = 32'h00000013;
  - PC_STEP = 4.
- No sub-module: the PC, FSM and output register are a single sequential block. The ROM is instantiated alongside fetch_ctrl by the core top, not inside it.

## Test plan
Stimulus uses the standard program (word0 = 0x00000013, word1 = 0x00500113, word2 = 0x00C00193, word12 = 0x0002AA03, MEM_DEPTH=32).

1. Reset, then fetch_en=1 and inst_ready=1: inst_valid rises 2 cycles after reset release with inst_out=0x00000013, inst_pc=0. It is then followed back-to-back by 0x00500113 at pc 4 and 0x00C00193 at pc 8.
2. Hold inst_ready=0 for 3 cycles while pc 4 is presented: inst_out stays 0x00500113, inst_pc=4, and pc stays 8. On inst_ready=1, the next cycle presents pc 8.
3. redirect_valid=1 with redirect_pc=0x33 and inst_ready=0: inst_valid drops next cycle. One cycle later inst_pc=0x30 and inst_out=0x0002AA03.
4. fetch_en=0 with one entry valid and inst_ready=1: the entry drains, inst_valid=0, and pc is unchanged until fetch_en=1.
5. With FETCH_BOUNDS_CHECK_EN, redirect to 0x80: the next cycle enters FAULT with fetch_fault=1 and inst_valid=0. A redirect to 0x0 clears the fault, and 0x00000013 appears 2 cycles later. Without the macro, the same stimulus fetches word 0 at pc 0x80.
6. Assert rst while inst_valid=1 mid-stream: inst_valid, inst_out, inst_pc and fetch_fault go to 0 asynchronously. Fetch restarts at RESET_PC with the 2-cycle latency.
